// File: rtl/fp32_div_seq.sv
// FP32 divide sequencer: unpacks operands, resolves special cases, drives the
// restoring mantissa divider for a fixed latency, then range-checks and packs.
module fp32_div_seq #(
  parameter int unsigned DIV_LATENCY = 146,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [47:0] div_num1,
  output logic [47:0] div_num2,
  output logic        div_rstn,
  input  logic [22:0] div_quotient,
  input  logic        div_normalize,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned FRAC_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic signed [EXP_W-1:0] BIAS    = 10'sd127;
  localparam logic signed [EXP_W-1:0] EXP_MAX = 10'sd255;
  localparam logic signed [EXP_W-1:0] EXP_MIN = 10'sd0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_LOAD, S_WAIT, S_PACK, S_OUT
  } state_t;

  state_t state, state_d;

  logic [31:0]             a_q, b_q, a_d, b_d;
  logic signed [EXP_W-1:0] e_q, e_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAC_W-1:0]       quo_q, quo_d;
  logic                    norm_q, norm_d;
  logic                    in_ready_d, out_valid_d, div_rstn_d;
  logic [47:0]             num1_d, num2_d;
  logic [31:0]             result_d;
  logic [3:0]              flags_d;

  // Classification of the captured operands
  logic [7:0]              ea, eb;
  logic                    sign;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EXP_W-1:0] e_unb, e_adj;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign sign   = a_q[31] ^ b_q[31];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == '0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == '0);
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != '0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != '0);
  assign e_unb  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
  assign e_adj  = e_q - $signed({{(EXP_W-1){1'b0}}, norm_q});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state and next register values
  always_comb begin
    state_d     = state;
    a_d         = a_q;
    b_d         = b_q;
    e_d         = e_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    norm_d      = norm_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    div_rstn_d  = div_rstn;
    num1_d      = div_num1;
    num2_d      = div_num2;
    result_d    = result;
    flags_d     = flags;

    case (state)
      S_IDLE: begin
        in_ready_d = 1'b1;
        div_rstn_d = 1'b0;
        if (in_valid && in_ready) begin
          a_d        = a;
          b_d        = b;
          num1_d     = {1'b1, a[22:0], 24'b0};
          num2_d     = {24'b0, 1'b1, b[22:0]};
          in_ready_d = 1'b0;
          state_d    = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        flags_d = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = QNAN;
          flags_d  = 4'b1000;
          state_d  = S_OUT;
        end else if (a_inf || b_zero) begin
          result_d = {sign, 8'hFF, 23'b0};
          flags_d  = {1'b0, b_zero && !a_inf, 2'b00};
          state_d  = S_OUT;
        end else if (a_zero || b_inf) begin
          result_d = {sign, 31'b0};
          state_d  = S_OUT;
        end else begin
          e_d     = e_unb;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d      = '0;
        div_rstn_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Capture the divider outputs on the last cycle it is held out of reset
        if (cnt_q == CNT_LAST) begin
          quo_d      = div_quotient;
          norm_d     = div_normalize;
          div_rstn_d = 1'b0;
          state_d    = S_PACK;
        end
      end
      S_PACK: begin
        if (e_adj >= EXP_MAX) begin
          result_d = {sign, 8'hFF, 23'b0};
          flags_d  = 4'b0010;
        end else if (e_adj <= EXP_MIN) begin
          result_d = {sign, 31'b0};
          flags_d  = 4'b0001;
        end else begin
          result_d = {sign, e_adj[7:0], quo_q};
          flags_d  = 4'b0000;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      e_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      norm_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      div_rstn  <= 1'b0;
      div_num1  <= '0;
      div_num2  <= '0;
      result    <= '0;
      flags     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      e_q       <= e_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      norm_q    <= norm_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      div_rstn  <= div_rstn_d;
      div_num1  <= num1_d;
      div_num2  <= num2_d;
      result    <= result_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: directed and random divides against an integer
// reference, with a mantissa-divider stand-in that only settles after 145 cycles.
module tb_fp32_div_seq;
  localparam int unsigned DL       = 146;
  localparam int unsigned DIV_NEED = 145;
  localparam int          NORM_LAT = DL + 4;
  localparam int          SPEC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [47:0] div_num1, div_num2;
  logic        div_rstn;
  logic [22:0] div_quotient;
  logic        div_normalize;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;

  fp32_div_seq #(.DIV_LATENCY(DL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .div_num1(div_num1), .div_num2(div_num2), .div_rstn(div_rstn),
    .div_quotient(div_quotient), .div_normalize(div_normalize),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Rounded mantissa ratio: {normalize, fraction}
  function automatic logic [23:0] mant_div(input logic [23:0] ma, input logic [23:0] mb);
    logic [63:0] num, q;
    logic        n;
    if (mb == 24'd0) return 24'd0;
    n   = (ma < mb);
    num = 64'(ma) << (n ? 25 : 24);
    q   = (num + 64'(mb)) / (64'(mb) * 64'd2);
    return {n, 23'(q - 64'h80_0000)};
  endfunction

  // Divider stand-in: wrong answers until it has been out of reset long enough
  int unsigned rel_cnt = 0;
  logic [23:0] md;
  always @(posedge clk) rel_cnt <= div_rstn ? rel_cnt + 1 : 0;
  always_comb begin
    md = mant_div(div_num1[47:24], div_num2[23:0]);
    if (rel_cnt >= DIV_NEED) begin
      div_quotient  = md[22:0];
      div_normalize = md[23];
    end else begin
      div_quotient  = ~md[22:0];
      div_normalize = ~md[23];
    end
  end

  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output bit spec);
    int ex, ey, e;
    bit s, xz, yz, xi, yi, xn, yn;
    logic [23:0] m;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    spec = 1'b1;
    f    = 4'b0000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      r = 32'h7FC0_0000; f = 4'b1000;
    end else if (xi || yz) begin
      r = {s, 8'hFF, 23'b0}; f = (yz && !xi) ? 4'b0100 : 4'b0000;
    end else if (xz || yi) begin
      r = {s, 31'b0};
    end else begin
      spec = 1'b0;
      m = mant_div({1'b1, x[22:0]}, {1'b1, y[22:0]});
      e = ex - ey + 127 - int'(m[23]);
      if (e >= 255)    begin r = {s, 8'hFF, 23'b0}; f = 4'b0010; end
      else if (e <= 0) begin r = {s, 31'b0};        f = 4'b0001; end
      else             r = {s, 8'(e), m[22:0]};
    end
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    chk("accept_ready", 64'(in_ready), 64'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the result after an accept edge, checks it, then hands it off
  task automatic finish_op(input string tag, input logic [31:0] er, input logic [3:0] ef,
                           input int elat, input int hold);
    int lat = 0;
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) chk({tag, "_busy"}, 64'(in_ready), 64'd0);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_result"}, 64'(result), 64'(er));
      chk({tag, "_hold_flags"}, 64'(flags), 64'(ef));
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int unsigned s;
    s = $urandom_range(0, 9);
    m = 23'($urandom);
    if (s == 0) e = 8'd0;
    else if (s == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, m};
  endfunction

  logic [31:0] dv_a [7] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                            32'h8000_0000, 32'h7F00_0000, 32'h0080_0000};
  logic [31:0] dv_b [7] = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h4000_0000, 32'h0080_0000, 32'h7F00_0000};
  logic [31:0] dv_r [7] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'h7F80_0000, 32'h7FC0_0000,
                            32'h8000_0000, 32'h7F80_0000, 32'h0000_0000};
  logic [3:0]  dv_f [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0010, 4'b0001};
  int          dv_l [7] = '{NORM_LAT, NORM_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, NORM_LAT, NORM_LAT};

  initial begin
    logic [31:0] x, y, er;
    logic [3:0]  ef;
    bit          sp, seen_v;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_div_rstn", 64'(div_rstn), 64'd0);
    chk("rst_num1", 64'(div_num1), 64'd0);
    chk("rst_num2", 64'(div_num2), 64'd0);

    for (int i = 0; i < 7; i++) begin
      send(dv_a[i], dv_b[i]);
      finish_op($sformatf("dir%0d", i), dv_r[i], dv_f[i], dv_l[i], 0);
    end

    // Backpressure with a second request held while busy
    send(32'h40C0_0000, 32'h4000_0000);
    a = 32'h3F80_0000; b = 32'h4040_0000; in_valid = 1'b1;
    finish_op("bp_first", 32'h4040_0000, 4'b0000, NORM_LAT, 10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_op("bp_second", 32'h3EAA_AAAB, 4'b0000, NORM_LAT, 0);

    // Abort in the middle of the divider wait
    send(32'h40C0_0000, 32'h4000_0000);
    repeat (50) @(posedge clk);
    #1;
    chk("wait_div_rstn", 64'(div_rstn), 64'd1);
    chk("wait_num1", 64'(div_num1), 64'({1'b1, 23'h40_0000, 24'b0}));
    chk("wait_num2", 64'(div_num2), 64'({24'b0, 1'b1, 23'b0}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_div_rstn", 64'(div_rstn), 64'd0);
    seen_v = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (out_valid) seen_v = 1;
    end
    chk("abort_no_output", 64'(seen_v), 64'd0);
    send(32'h40C0_0000, 32'h4000_0000);
    finish_op("after_abort", 32'h4040_0000, 4'b0000, NORM_LAT, 0);

    for (int i = 0; i < 30; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      ref_div(x, y, er, ef, sp);
      send(x, y);
      finish_op($sformatf("rnd%0d_%h_%h", i, x, y), er, ef, sp ? SPEC_LAT : NORM_LAT,
                int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Upstream sequencer for the 48-bit restoring mantissa divider in the FP32 divide path.
- Accepts two IEEE-754 single operands over a valid/ready handshake, unpacks them, and detects special cases.
- Loads and launches the mantissa divider, waits for its fixed latency, then applies exponent adjust, range checks and packing.
- Produces one FP32 quotient per operation on an output valid/ready handshake.

Parameters:
- DIV_LATENCY, 146, cycles from divider reset release to sampling its quotient/normalize outputs (divider needs 145).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  32  dividend, FP32
- b  input  32  divisor, FP32
- div_num1  output  48  divider dividend, {1'b1, a[22:0], 24'b0}
- div_num2  output  48  divider divisor, {24'b0, 1'b1, b[22:0]}
- div_rstn  output  1  divider load/reset, active low
- div_quotient  input  23  divider fraction result, already rounded
- div_normalize  input  1  1 = mantissa ratio < 1
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  32  FP32 quotient
- flags  output  4  {invalid, div_by_zero, overflow, underflow}

Behaviour:
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, result=0, flags=0.
  - div_rstn=0, div_num1=0, div_num2=0, counter=0.
- The clock and reset are one clock with a synchronous, active-high reset. rst wins over every other event in the same cycle.
- rst in any state aborts the operation: no output and no partial result.
- Unpack rules:
  - sign = a[31]^b[31]; ea=a[30:23], eb=b[30:23].
  - Exponent field 0 is treated as zero (denormals flushed).
  - Exponent field 255 is treated as inf or NaN depending on the fraction.
- States:
  - IDLE: in_ready=1, div_rstn=0. On in_valid, register a and b, then go to CLASSIFY. in_ready drops the next cycle.
  - CLASSIFY (1 cycle): check specials in priority order:
    - Either operand NaN, 0/0, or inf/inf: result 0x7FC00000, invalid=1.
    - a inf or b zero with a nonzero: signed inf {sign, 0xFF, 0}. div_by_zero=1 only for b zero and a finite.
    - a zero or b inf: signed zero.
    - Any special goes to OUT. Otherwise drive div_num1/div_num2, compute e = ea - eb + 127 as 10-bit signed, and go to LOAD.
  - LOAD (1 cycle): div_rstn=0 with operands stable, counter cleared. Go to WAIT.
  - WAIT: div_rstn=1 and counter increments each cycle. When counter == DIV_LATENCY-1, go to PACK.
  - PACK (1 cycle):
    - e_adj = e - div_normalize.
    - e_adj >= 255: {sign, 0xFF, 0}, overflow=1.
    - e_adj <= 0: {sign, 31'b0}, underflow=1.
    - Otherwise: {sign, e_adj[7:0], div_quotient}.
    - div_rstn returns to 0. Go to OUT.
  - OUT: out_valid=1; result and flags held stable until out_ready. On out_valid && out_ready, out_valid=0, in_ready=1, go to IDLE.
- Latency:
  - Normal operand: DIV_LATENCY+4 cycles from accept to out_valid.
  - Special operand: 2 cycles.
- Throughput: one operation in flight; in_ready=0 from the cycle after accept until the output handshake completes.
- in_valid while busy is ignored; the upstream must hold it.
- Output handshake: result must not change while out_valid=1 && out_ready=0.
- div_num1/div_num2 hold stable from CLASSIFY through PACK.
- flags are zero for every normal in-range result.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000, flags 0, out_valid exactly DIV_LATENCY+4 cycles after accept.
- a=0x3F800000, b=0x40400000 (1/3) -> result 0x3EAAAAAB, flags 0; div_normalize=1 path exercised.
- Specials:
  - a=0x3F800000, b=0x00000000 -> 0x7F800000, flags 4'b0100.
  - a=b=0 -> 0x7FC00000, flags 4'b1000.
  - a=0x80000000, b=0x40000000 -> 0x80000000, flags 0.
  - All with 2-cycle latency.
- Range:
  - a=0x7F000000, b=0x00800000 -> 0x7F800000, flags 4'b0010.
  - a=0x00800000, b=0x7F000000 -> 0x00000000, flags 4'b0001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, a second in_valid ignored. Then out_ready=1 -> next cycle in_ready=1, second op accepted.
- rst asserted mid-WAIT (cycle 50) -> next cycle IDLE, in_ready=1, out_valid=0, div_rstn=0. No result is ever emitted for the aborted op; a following 6.0/2.0 returns 0x40400000.
